// File: rtl/vga_marquee_sequencer.sv
// Scrolling-marquee sequencer: holds a short message of 5-bit letter codes,
// returns the letter for the slot being drawn, scrolls one slot every
// SCROLL_FRAMES frames and latches the colour theme only at frame boundaries.
module vga_marquee_sequencer #(
  parameter int SLOTS         = 8,
  parameter int MSG_LEN_MAX   = 16,
  parameter int SCROLL_FRAMES = 30,
  parameter int BLANK         = 31,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int LEN_W  = $clog2(MSG_LEN_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_letter,
  output logic              wr_ready,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic              frame_tick,
  input  logic [SLOT_W-1:0] slot_idx,
  input  logic [1:0]        theme_in,
  output logic [4:0]        letter_out,
  output logic [1:0]        theme_out,
  output logic              busy,
  output logic [LEN_W-1:0]  msg_len
);

  // Buffer index width, position width (covers offset+slot_idx < 2L) and
  // frame counter width.
  localparam int IDX_W = (MSG_LEN_MAX > 1) ? $clog2(MSG_LEN_MAX) : 1;
  localparam int POS_W = $clog2(2 * (MSG_LEN_MAX + SLOTS));
  localparam int FC_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  msg_len_q, msg_len_d;
  logic [POS_W-1:0]  offset_q, offset_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [4:0]        letter_q, letter_d;
  logic [1:0]        theme_q, theme_d;
  logic              wr_acc;

  logic [4:0]        buf_q [MSG_LEN_MAX];

  logic [POS_W-1:0]  len_virt;
  logic [POS_W-1:0]  pos_sum;
  logic [POS_W-1:0]  pos;
  logic [IDX_W-1:0]  wr_idx;

  assign wr_ready   = (state_q == IDLE) && (msg_len_q < LEN_W'(MSG_LEN_MAX));
  assign busy       = (state_q == RUN);
  assign msg_len    = msg_len_q;
  assign letter_out = letter_q;
  assign theme_out  = theme_q;
  assign wr_idx     = msg_len_q[IDX_W-1:0];

  // Virtual message length includes a blank gap of SLOTS slots; since
  // offset < L and slot_idx < SLOTS <= L, one conditional subtract wraps it.
  assign len_virt = POS_W'(msg_len_q) + POS_W'(SLOTS);
  assign pos_sum  = offset_q + POS_W'(slot_idx);
  assign pos      = (pos_sum >= len_virt) ? (pos_sum - len_virt) : pos_sum;

  // Next-state and datapath update for both FSM states.
  always_comb begin
    state_d     = state_q;
    msg_len_d   = msg_len_q;
    offset_d    = offset_q;
    frame_cnt_d = frame_cnt_q;
    letter_d    = 5'(BLANK);
    theme_d     = frame_tick ? theme_in : theme_q;
    wr_acc      = 1'b0;
    case (state_q)
      IDLE: begin
        // clear beats a same-cycle write; start sees the post-write length
        wr_acc = wr_en && wr_ready && !clear;
        if (clear) begin
          msg_len_d = '0;
        end else if (wr_acc) begin
          msg_len_d = msg_len_q + LEN_W'(1);
        end
        if (start && (msg_len_d != '0)) begin
          state_d = RUN;
        end
        offset_d    = '0;
        frame_cnt_d = '0;
      end
      RUN: begin
        if (stop) begin
          // stop wins over a same-cycle frame_tick: no scroll step
          state_d     = IDLE;
          offset_d    = '0;
          frame_cnt_d = '0;
        end else begin
          letter_d = (pos < POS_W'(msg_len_q)) ? buf_q[pos[IDX_W-1:0]] : 5'(BLANK);
          if (frame_tick) begin
            if (frame_cnt_q == FC_W'(SCROLL_FRAMES - 1)) begin
              frame_cnt_d = '0;
              offset_d    = (offset_q == len_virt - POS_W'(1)) ? '0 : offset_q + POS_W'(1);
            end else begin
              frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      msg_len_q   <= '0;
      offset_q    <= '0;
      frame_cnt_q <= '0;
      letter_q    <= 5'(BLANK);
      theme_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      msg_len_q   <= msg_len_d;
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
      letter_q    <= letter_d;
      theme_q     <= theme_d;
    end
  end

  // Message storage; contents are meaningless past msg_len so no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      buf_q[wr_idx] <= wr_letter;
    end
  end

endmodule

// File: tb/tb_vga_marquee_sequencer.sv
// Self-checking bench for vga_marquee_sequencer with a letter scoreboard.
module tb_vga_marquee_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, clear, start, stop, frame_tick;
  logic [4:0] wr_letter;
  logic       wr_ready;
  logic [2:0] slot_idx;
  logic [1:0] theme_in;
  logic [4:0] letter_out;
  logic [1:0] theme_out;
  logic       busy;
  logic [4:0] msg_len;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mlen, moff, mcnt, mtheme;
  bit mrun;
  int mmsg [16];
  logic [4:0] sb [$];

  vga_marquee_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_letter(wr_letter), .wr_ready(wr_ready),
    .clear(clear), .start(start), .stop(stop), .frame_tick(frame_tick),
    .slot_idx(slot_idx), .theme_in(theme_in), .letter_out(letter_out),
    .theme_out(theme_out), .busy(busy), .msg_len(msg_len)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_letter(input int s);
    int p;
    p = (moff + s) % (mlen + 8);
    return (p < mlen) ? 5'(mmsg[p]) : 5'd31;
  endfunction

  // All tasks begin and end at a falling edge.
  task automatic write_letter(input int v);
    wr_en = 1'b1; wr_letter = 5'(v);
    @(negedge clk);
    wr_en = 1'b0;
    if (!mrun && mlen < 16) begin mmsg[mlen] = v; mlen++; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!mrun && mlen > 0) mrun = 1;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    mrun = 0; moff = 0; mcnt = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      mtheme = theme_in;
      if (mrun) begin
        if (mcnt == 29) begin mcnt = 0; moff = (moff + 1) % (mlen + 8); end
        else mcnt++;
      end
      @(negedge clk);
    end
  endtask

  // Sweep all slots; expected letter queued when slot_idx is driven,
  // compared one clock later.
  task automatic scan(input string tag);
    logic [4:0] exp;
    for (int s = 0; s < 8; s++) begin
      slot_idx = 3'(s);
      sb.push_back(model_letter(s));
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (letter_out !== exp) begin
        errors++;
        $display("FAIL %s slot=%0d off=%0d: letter_out=%0d expected=%0d", tag, s, moff, letter_out, exp);
      end
    end
    slot_idx = 3'd0;
  endtask

  task automatic test_reset();
    checks++; if (letter_out !== 5'd31) begin errors++; $display("FAIL reset_letter: got %0d expected 31", letter_out); end
    checks++; if (theme_out !== 2'b00) begin errors++; $display("FAIL reset_theme: got %0d expected 0", theme_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (msg_len !== 5'd0) begin errors++; $display("FAIL reset_msg_len: got %0d expected 0", msg_len); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %0b expected 1", wr_ready); end
  endtask

  task automatic test_write_scan();
    write_letter(0); write_letter(1); write_letter(2);
    checks++; if (msg_len !== 5'(mlen)) begin errors++; $display("FAIL abc_len: got %0d expected %0d", msg_len, mlen); end
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abc_busy: got %0b expected 1", busy); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL run_wr_ready: got %0b expected 0", wr_ready); end
    scan("abc_scan");
  endtask

  task automatic test_scroll();
    ticks(30);
    scan("scroll_off1");
    ticks(270);
    scan("scroll_off10");
    ticks(30);
    checks++; if (moff != 0) begin errors++; $display("FAIL model_wrap: offset %0d expected 0", moff); end
    scan("scroll_wrap");
  endtask

  task automatic test_theme_stop();
    theme_in = 2'b01;
    repeat (3) @(negedge clk);
    checks++; if (theme_out !== 2'(mtheme)) begin errors++; $display("FAIL theme_hold: got %0d expected %0d", theme_out, mtheme); end
    ticks(1);
    checks++; if (theme_out !== 2'b01) begin errors++; $display("FAIL theme_tick: got %0d expected 1", theme_out); end
    ticks(28);
    // frame counter is now 29: stop and tick together
    theme_in = 2'b10;
    stop = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    stop = 1'b0; frame_tick = 1'b0;
    mrun = 0; moff = 0; mcnt = 0; mtheme = 2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %0b expected 0", busy); end
    checks++; if (letter_out !== 5'd31) begin errors++; $display("FAIL stop_letter: got %0d expected 31", letter_out); end
    checks++; if (theme_out !== 2'b10) begin errors++; $display("FAIL stop_theme: got %0d expected 2", theme_out); end
    pulse_start();
    ticks(29);
    scan("restart_29");
    ticks(1);
    scan("restart_30");
    pulse_stop();
  endtask

  task automatic test_idle_edges();
    clear = 1'b1; @(negedge clk); clear = 1'b0; mlen = 0;
    checks++; if (msg_len !== 5'd0) begin errors++; $display("FAIL clear_len: got %0d expected 0", msg_len); end
    pulse_start();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_start: busy %0b expected 0", busy); end
    wr_en = 1'b1; wr_letter = 5'd7; clear = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; clear = 1'b0;
    checks++; if (msg_len !== 5'd0) begin errors++; $display("FAIL clear_prio: got %0d expected 0", msg_len); end
    wr_en = 1'b1; wr_letter = 5'd9; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    mmsg[0] = 9; mlen = 1; mrun = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_wr_busy: got %0b expected 1", busy); end
    checks++; if (msg_len !== 5'd1) begin errors++; $display("FAIL start_wr_len: got %0d expected 1", msg_len); end
    scan("start_wr_scan");
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_in_run: busy %0b expected 1", busy); end
    pulse_stop();
  endtask

  task automatic test_full();
    clear = 1'b1; @(negedge clk); clear = 1'b0; mlen = 0;
    for (int k = 0; k < 17; k++) begin
      write_letter(k + 5);
      if (k == 14) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready15: got %0b expected 1", wr_ready); end
      end
      if (k == 15) begin
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready16: got %0b expected 0", wr_ready); end
      end
    end
    checks++; if (msg_len !== 5'd16) begin errors++; $display("FAIL full_len: got %0d expected 16", msg_len); end
    pulse_start();
    clear = 1'b1; wr_en = 1'b1; wr_letter = 5'd1;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    checks++; if (msg_len !== 5'd16) begin errors++; $display("FAIL run_clear: got %0d expected 16", msg_len); end
    scan("full_scan");
  endtask

  task automatic test_reset_mid_run();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %0b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    mrun = 0; mlen = 0; moff = 0; mcnt = 0; mtheme = 0;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
    frame_tick = 1'b0; wr_letter = 5'd0; slot_idx = 3'd0; theme_in = 2'b00;
    mrun = 0; mlen = 0; moff = 0; mcnt = 0; mtheme = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_scan();
    test_scroll();
    test_theme_stop();
    test_idle_edges();
    test_full();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
